// File: rtl/frame_scheduler.sv
// frame_scheduler: divides clk into a fixed frame period and sequences four update phases per frame.
// Define SCHED_WATCHDOG_EN to add a per-phase watchdog that skips a stuck phase and flags timeout_err.
module frame_scheduler #(
  parameter int TICK_CYCLES    = 1_000_000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pause,
  input  logic        clr_err,
  input  logic [3:0]  phase_done,
  output logic        frame_tick,
  output logic [3:0]  phase_start,
  output logic [1:0]  phase_id,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        timeout_err
);

  // bit3 = waiting, bit2 = starting, bits[1:0] = phase index
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
    S_START0 = 4'b0100,
    S_START1 = 4'b0101,
    S_START2 = 4'b0110,
    S_START3 = 4'b0111,
    S_WAIT0  = 4'b1000,
    S_WAIT1  = 4'b1001,
    S_WAIT2  = 4'b1010,
    S_WAIT3  = 4'b1011
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);

  if (TICK_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("frame_scheduler: TICK_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_tick;
  logic [1:0]       r_phase_id;
  logic [15:0]      r_frame_cnt;
  logic             r_overrun;
  logic             w_tick;
  logic             w_in_wait;
  logic             w_in_start;
  logic [1:0]       w_idx;
  logic             w_expire;
  logic             w_adv;
  logic             w_accept;
  logic             w_frame_done;
  logic [3:0]       w_start;

  // Frame tick counter: en=0 clears, pause freezes, wrap edge is the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (!pause) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign w_tick     = en & ~pause & (r_cnt == LAST_CNT);
  assign w_in_wait  = r_state[3] & ~r_state[2];
  assign w_in_start = r_state[2] & ~r_state[3];
  assign w_idx      = r_state[1:0];
  assign w_adv      = w_in_wait & (phase_done[w_idx] | w_expire);

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_frame_done = 1'b0;
    w_start      = 4'b0000;
    if (w_in_start) begin
      w_start = 4'b0001 << w_idx;
      w_next  = state_t'({2'b10, w_idx});
    end else if (w_in_wait) begin
      if (w_adv) begin
        if (w_idx == 2'd3) begin
          // a tick landing on the final done starts the next frame without overrun
          w_frame_done = 1'b1;
          w_accept     = w_tick;
          w_next       = w_tick ? S_START0 : S_IDLE;
        end else begin
          w_next = state_t'({2'b01, w_idx + 2'd1});
        end
      end
    end else begin
      w_next = S_IDLE;
      if (r_state == S_IDLE && w_tick) begin
        w_accept = 1'b1;
        w_next   = S_START0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_frame_tick <= 1'b0;
      r_phase_id   <= 2'd0;
      r_frame_cnt  <= 16'd0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_tick <= w_tick;
      if (w_in_start) begin
        r_phase_id <= w_idx;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_tick && !w_accept) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;

  // Restarts on every non-WAIT cycle, so each WAITn begins counting from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= w_in_wait ? r_wd + WD_W'(1) : '0;
      if (w_expire && !phase_done[w_idx]) begin
        r_timeout <= 1'b1;
      end else if (clr_err) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign w_expire    = w_in_wait & (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign frame_tick  = r_frame_tick;
  assign phase_start = w_start;
  assign phase_id    = r_phase_id;
  assign busy        = (r_state != S_IDLE);
  assign frame_cnt   = r_frame_cnt;
  assign overrun     = r_overrun;

endmodule
